midi_tx_scheduler: RTL and testbench

//  Shares one MIDI UART transmitter between N message sources (theremin note sender, control/pitch-bend

---
 rtl/midi_tx_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_midi_tx_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx_scheduler.sv
// Round-robin scheduler that shares one MIDI UART transmitter between N_REQ message sources.
// It latches a 3-byte message, then sends it byte by byte under uart_ready, with optional running status.
module midi_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter bit RUNNING_STATUS = 1'b1,
    parameter int RS_REFRESH     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] status_in,
    input  logic [8*N_REQ-1:0] data1_in,
    input  logic [8*N_REQ-1:0] data2_in,
    output logic [N_REQ-1:0]   grant_ack,
    output logic [7:0]         midi_byte,
    output logic               midi_send,
    input  logic               uart_ready,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, S_STAT, S_D1, S_D2, GAP} state_t;

    state_t           r_state, w_state_n;
    state_t           r_ret, w_ret_n;
    logic [PW-1:0]    r_ptr, w_ptr_n;
    logic [7:0]       r_stat, w_stat_n;
    logic [7:0]       r_d1, w_d1_n;
    logic [7:0]       r_d2, w_d2_n;
    logic [7:0]       r_last_stat, w_last_stat_n;
    logic             r_ls_valid, w_ls_valid_n;
    logic [7:0]       r_rs_cnt, w_rs_cnt_n;
    logic [N_REQ-1:0] r_grant_ack, w_grant_ack_n;
    logic [7:0]       r_midi_byte, w_midi_byte_n;
    logic             r_midi_send, w_midi_send_n;
    logic             r_busy, w_busy_n;

    logic [7:0]       w_stat_arr [N_REQ];
    logic [7:0]       w_d1_arr   [N_REQ];
    logic [7:0]       w_d2_arr   [N_REQ];
    logic             w_found;
    logic [PW-1:0]    w_sel;
    logic [PW-1:0]    w_idx;
    logic [7:0]       w_sel_stat;
    logic             w_skip;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_stat_arr[i] = status_in[8*i +: 8];
            w_d1_arr[i]   = data1_in[8*i +: 8];
            w_d2_arr[i]   = data2_in[8*i +: 8];
        end
    end

    // Round-robin search: first set request strictly after the last granted index, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_sel_stat = w_stat_arr[w_sel] | 8'h80;
    assign w_skip     = RUNNING_STATUS && r_ls_valid && (w_sel_stat == r_last_stat)
                        && (r_rs_cnt < 8'(RS_REFRESH));

    // NOTE: every variable gets its default before the case, so no path can infer a latch.
    always_comb begin
        w_state_n     = r_state;
        w_ret_n       = r_ret;
        w_ptr_n       = r_ptr;
        w_stat_n      = r_stat;
        w_d1_n        = r_d1;
        w_d2_n        = r_d2;
        w_last_stat_n = r_last_stat;
        w_ls_valid_n  = r_ls_valid;
        w_rs_cnt_n    = r_rs_cnt;
        w_grant_ack_n = '0;
        w_midi_byte_n = r_midi_byte;
        w_midi_send_n = 1'b0;
        w_busy_n      = r_busy;

        unique case (r_state)
            IDLE: begin
                w_busy_n = 1'b0;
                if (w_found) begin
                    w_stat_n              = w_sel_stat;
                    w_d1_n                = w_d1_arr[w_sel] & 8'h7F;
                    w_d2_n                = w_d2_arr[w_sel] & 8'h7F;
                    w_ptr_n               = w_sel;
                    w_grant_ack_n[w_sel]  = 1'b1;
                    w_busy_n              = 1'b1;
                    if (w_skip) begin
                        w_state_n  = S_D1;
                        w_rs_cnt_n = (r_rs_cnt == 8'hFF) ? r_rs_cnt : r_rs_cnt + 8'd1;
                    end else begin
                        w_state_n  = S_STAT;
                    end
                end
            end
            S_STAT: begin
                if (uart_ready) begin
                    w_midi_byte_n = r_stat;
                    w_midi_send_n = 1'b1;
                    w_last_stat_n = r_stat;
                    w_ls_valid_n  = 1'b1;
                    w_rs_cnt_n    = 8'd0;
                    w_ret_n       = S_D1;
                    w_state_n     = GAP;
                end
            end
            S_D1: begin
                if (uart_ready) begin
                    w_midi_byte_n = r_d1;
                    w_midi_send_n = 1'b1;
                    w_ret_n       = S_D2;
                    w_state_n     = GAP;
                end
            end
            S_D2: begin
                if (uart_ready) begin
                    w_midi_byte_n = r_d2;
                    w_midi_send_n = 1'b1;
                    w_ret_n       = IDLE;
                    w_state_n     = GAP;
                end
            end
            GAP: begin
                // One dead cycle after each strobe so a stale uart_ready cannot double-fire.
                w_state_n = r_ret;
                if (r_ret == IDLE) w_busy_n = 1'b0;
            end
            default: w_state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ret       <= IDLE;
            r_ptr       <= PW'(N_REQ - 1);
            r_stat      <= 8'd0;
            r_d1        <= 8'd0;
            r_d2        <= 8'd0;
            r_last_stat <= 8'd0;
            r_ls_valid  <= 1'b0;
            r_rs_cnt    <= 8'd0;
            r_grant_ack <= '0;
            r_midi_byte <= 8'd0;
            r_midi_send <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ret       <= w_ret_n;
            r_ptr       <= w_ptr_n;
            r_stat      <= w_stat_n;
            r_d1        <= w_d1_n;
            r_d2        <= w_d2_n;
            r_last_stat <= w_last_stat_n;
            r_ls_valid  <= w_ls_valid_n;
            r_rs_cnt    <= w_rs_cnt_n;
            r_grant_ack <= w_grant_ack_n;
            r_midi_byte <= w_midi_byte_n;
            r_midi_send <= w_midi_send_n;
            r_busy      <= w_busy_n;
        end
    end

    assign grant_ack = r_grant_ack;
    assign midi_byte = r_midi_byte;
    assign midi_send = r_midi_send;
    assign busy      = r_busy;

endmodule

// File: tb/tb_midi_tx_scheduler.sv
// Directed testbench for midi_tx_scheduler: byte sequencing, running status, round-robin,
// ready back-pressure, mid-message reset and byte masking.
module tb_midi_tx_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] status_in = '0;
    logic [8*N-1:0] data1_in = '0;
    logic [8*N-1:0] data2_in = '0;
    logic [N-1:0]   grant_ack;
    logic [7:0]     midi_byte;
    logic           midi_send;
    logic           uart_ready = 1'b1;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] q_bytes [$];
    int         q_cyc   [$];
    int         q_gnt   [$];

    midi_tx_scheduler #(.N_REQ(N), .RUNNING_STATUS(1'b1), .RS_REFRESH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .status_in  (status_in),
        .data1_in   (data1_in),
        .data2_in   (data2_in),
        .grant_ack  (grant_ack),
        .midi_byte  (midi_byte),
        .midi_send  (midi_send),
        .uart_ready (uart_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every strobe and every grant, sampled mid-cycle.
    always @(negedge clk) begin
        if (midi_send === 1'b1) begin
            q_bytes.push_back(midi_byte);
            q_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++)
            if (grant_ack[i] === 1'b1) q_gnt.push_back(i);
    end

    function automatic logic [7:0] byte_at(input int k);
        if (k < q_bytes.size()) return q_bytes[k];
        return 8'hxx;
    endfunction

    function automatic int gnt_at(input int k);
        if (k < q_gnt.size()) return q_gnt[k];
        return -1;
    endfunction

    task automatic clear_logs();
        q_bytes.delete();
        q_cyc.delete();
        q_gnt.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        uart_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
    endtask

    // Present one message on requester idx, drop req on its ack, wait for busy to clear.
    // len = negedges from the ack sample to the first sample with busy low.
    task automatic send_msg(input int idx, input logic [7:0] s, input logic [7:0] d1,
                            input logic [7:0] d2, output int len, output bit ok);
        int n;
        ok  = 1'b1;
        len = 0;
        status_in[8*idx +: 8] = s;
        data1_in[8*idx +: 8]  = d1;
        data2_in[8*idx +: 8]  = d2;
        req[idx] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_ack[idx] !== 1'b1 && n < 50);
        if (grant_ack[idx] !== 1'b1) ok = 1'b0;
        req[idx] = 1'b0;
        while (busy !== 1'b0 && len < 500) begin
            @(negedge clk);
            len++;
        end
        if (busy !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (grant_ack !== '0)    begin n_err++; $display("FAIL reset_grant_ack got=%b exp=0", grant_ack); end
        n_vec++; if (midi_byte !== 8'h00) begin n_err++; $display("FAIL reset_midi_byte got=%h exp=00", midi_byte); end
        n_vec++; if (midi_send !== 1'b0)  begin n_err++; $display("FAIL reset_midi_send got=%b exp=0", midi_send); end
        n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0 || midi_send !== 1'b0 || grant_ack !== '0) begin
            n_err++; $display("FAIL idle_no_req got busy=%b send=%b ack=%b exp=0/0/0", busy, midi_send, grant_ack);
        end
        clear_logs();
    endtask

    task automatic test_single_msg();
        logic [7:0] exp [3];
        int len;
        bit ok;
        exp[0] = 8'h90; exp[1] = 8'h3C; exp[2] = 8'h64;
        do_reset();
        send_msg(0, 8'h90, 8'd60, 8'd100, len, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout got=0 exp=1"); end
        n_vec++; if (q_bytes.size() != 3) begin n_err++; $display("FAIL single_nbytes got=%0d exp=3", q_bytes.size()); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (byte_at(k) !== exp[k]) begin n_err++; $display("FAIL single_byte%0d got=%h exp=%h", k, byte_at(k), exp[k]); end
        end
        for (int k = 1; k < 3 && k < q_cyc.size(); k++) begin
            n_vec++;
            if (q_cyc[k] - q_cyc[k-1] != 2) begin
                n_err++; $display("FAIL single_spacing%0d got=%0d exp=2", k, q_cyc[k] - q_cyc[k-1]);
            end
        end
        n_vec++; if (len != 6) begin n_err++; $display("FAIL single_busy_len got=%0d exp=6", len); end
        n_vec++; if (q_gnt.size() != 1 || gnt_at(0) != 0) begin
            n_err++; $display("FAIL single_grant got=%0d acks first=%0d exp=1 acks first=0", q_gnt.size(), gnt_at(0));
        end
    endtask

    task automatic test_running_status();
        int  nb  [20];
        logic [7:0] fb [20];
        int  lens [20];
        int  bad_count;
        bit  ok;
        bit  all_ok;
        do_reset();
        all_ok = 1'b1;
        for (int m = 1; m <= 19; m++) begin
            clear_logs();
            send_msg(0, 8'h90, 8'h3C, 8'h64, lens[m], ok);
            if (!ok) all_ok = 1'b0;
            nb[m] = q_bytes.size();
            fb[m] = byte_at(0);
        end
        n_vec++; if (!all_ok) begin n_err++; $display("FAIL rs_timeout got=0 exp=1"); end
        n_vec++; if (nb[1] != 3 || fb[1] !== 8'h90) begin n_err++; $display("FAIL rs_msg1 got=%0d bytes first=%h exp=3 bytes first=90", nb[1], fb[1]); end
        n_vec++; if (nb[2] != 2 || fb[2] !== 8'h3C) begin n_err++; $display("FAIL rs_msg2 got=%0d bytes first=%h exp=2 bytes first=3c", nb[2], fb[2]); end
        n_vec++; if (lens[2] != 4) begin n_err++; $display("FAIL rs_busy_len got=%0d exp=4", lens[2]); end
        bad_count = 0;
        for (int m = 2; m <= 17; m++) if (nb[m] != 2) bad_count++;
        n_vec++; if (bad_count != 0) begin n_err++; $display("FAIL rs_skip_msgs got=%0d wrong exp=0 wrong", bad_count); end
        n_vec++; if (nb[18] != 3 || fb[18] !== 8'h90) begin n_err++; $display("FAIL rs_refresh got=%0d bytes first=%h exp=3 bytes first=90", nb[18], fb[18]); end
        n_vec++; if (nb[19] != 2) begin n_err++; $display("FAIL rs_after_refresh got=%0d exp=2", nb[19]); end
    endtask

    task automatic test_round_robin();
        int exp [6];
        int n;
        exp[0] = 0; exp[1] = 1; exp[2] = 3; exp[3] = 0; exp[4] = 1; exp[5] = 3;
        do_reset();
        for (int i = 0; i < N; i++) begin
            status_in[8*i +: 8] = 8'h90 + 8'(i);
            data1_in[8*i +: 8]  = 8'(i);
            data2_in[8*i +: 8]  = 8'h10;
        end
        req = 4'b1011;
        n = 0;
        while (q_gnt.size() < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req = '0;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (q_gnt.size() < 6) begin n_err++; $display("FAIL rr_timeout got=%0d grants exp=6", q_gnt.size()); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (gnt_at(k) != exp[k]) begin n_err++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, gnt_at(k), exp[k]); end
        end
    endtask

    task automatic test_ready_backpressure();
        logic [7:0] exp [3];
        int low_strobes;
        int busy_drops;
        int n;
        exp[0] = 8'hB0; exp[1] = 8'h07; exp[2] = 8'h40;
        do_reset();
        uart_ready = 1'b0;
        status_in[7:0] = 8'hB0;
        data1_in[7:0]  = 8'h07;
        data2_in[7:0]  = 8'h40;
        req[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_ack[0] !== 1'b1 && n < 20);
        req[0] = 1'b0;
        n_vec++; if (grant_ack[0] !== 1'b1) begin n_err++; $display("FAIL bp_grant got=%b exp=1", grant_ack[0]); end
        for (int b = 0; b < 3; b++) begin
            low_strobes = 0;
            busy_drops  = 0;
            repeat (20) begin
                @(negedge clk);
                if (midi_send !== 1'b0) low_strobes++;
                if (busy !== 1'b1) busy_drops++;
            end
            n_vec++; if (low_strobes != 0) begin n_err++; $display("FAIL bp_strobe_low%0d got=%0d exp=0", b, low_strobes); end
            n_vec++; if (busy_drops != 0)  begin n_err++; $display("FAIL bp_busy%0d got=%0d low cycles exp=0", b, busy_drops); end
            uart_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if (midi_send !== 1'b1 || midi_byte !== exp[b]) begin
                n_err++; $display("FAIL bp_byte%0d got send=%b byte=%h exp send=1 byte=%h", b, midi_send, midi_byte, exp[b]);
            end
            uart_ready = 1'b0;
        end
        n = 0;
        while (busy !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
        uart_ready = 1'b1;
    endtask

    task automatic test_reset_mid_msg();
        int n;
        int len;
        bit ok;
        do_reset();
        status_in[7:0] = 8'h90;
        data1_in[7:0]  = 8'h3C;
        data2_in[7:0]  = 8'h64;
        req[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_ack[0] !== 1'b1 && n < 20);
        req[0] = 1'b0;
        n = 0;
        while (midi_send !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (midi_byte !== 8'h90) begin n_err++; $display("FAIL mid_first_byte got=%h exp=90", midi_byte); end
        rst = 1'b1;
        #1;
        n_vec++;
        if (midi_send !== 1'b0 || midi_byte !== 8'h00 || busy !== 1'b0 || grant_ack !== '0) begin
            n_err++; $display("FAIL mid_async_clear got send=%b byte=%h busy=%b ack=%b exp 0/00/0/0",
                              midi_send, midi_byte, busy, grant_ack);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        send_msg(0, 8'h90, 8'h3C, 8'h64, len, ok);
        n_vec++;
        if (!ok || q_bytes.size() != 3 || byte_at(0) !== 8'h90 || byte_at(1) !== 8'h3C || byte_at(2) !== 8'h64) begin
            n_err++; $display("FAIL mid_resend got n=%0d %h %h %h exp n=3 90 3c 64",
                              q_bytes.size(), byte_at(0), byte_at(1), byte_at(2));
        end
    endtask

    task automatic test_masking();
        logic [7:0] exp [3];
        int len;
        bit ok;
        exp[0] = 8'h90; exp[1] = 8'h7F; exp[2] = 8'h00;
        do_reset();
        send_msg(2, 8'h10, 8'hFF, 8'h80, len, ok);
        n_vec++; if (!ok || q_bytes.size() != 3) begin n_err++; $display("FAIL mask_nbytes got=%0d exp=3", q_bytes.size()); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (byte_at(k) !== exp[k]) begin n_err++; $display("FAIL mask_byte%0d got=%h exp=%h", k, byte_at(k), exp[k]); end
        end
        n_vec++; if (gnt_at(0) != 2) begin n_err++; $display("FAIL mask_grant got=%0d exp=2", gnt_at(0)); end
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_running_status();
        test_round_robin();
        test_ready_backpressure();
        test_reset_mid_msg();
        test_masking();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
